// File: rtl/wbq_pkg.sv
// Shared types and helpers for the write-back queue.
// Widths here are the core's default register-file geometry.
package wbq_pkg;

  localparam int WBQ_ADDR_W    = 5;
  localparam int WBQ_DATA_W    = 32;
  // Pointer helper operates on this fixed width; callers cast to their own width.
  localparam int WBQ_PTR_MAX_W = 8;

  typedef struct packed {
    logic [WBQ_ADDR_W-1:0] rd;
    logic [WBQ_DATA_W-1:0] data;
  } wbq_entry_t;

  // Wrapping increment of a circular-buffer pointer for a queue of 'depth' entries.
  function automatic logic [WBQ_PTR_MAX_W-1:0] wbq_ptr_inc(
    input logic [WBQ_PTR_MAX_W-1:0] ptr,
    input int unsigned              depth
  );
    logic [WBQ_PTR_MAX_W-1:0] nxt;
    if ({24'd0, ptr} == (depth - 32'd1)) begin
      nxt = 8'd0;
    end else begin
      nxt = ptr + 8'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/wbq_match.sv
// One lookup port of the write-back queue: reports whether a pending
// entry targets 'src' and, with WBQ_BYPASS_EN, the youngest such entry's data.
// Optional feature macro: WBQ_BYPASS_EN.
module wbq_match
  import wbq_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = WBQ_ADDR_W,
  parameter int unsigned DATA_W = WBQ_DATA_W,
  parameter int unsigned PTR_W  = 2
) (
  input  logic [DEPTH*ADDR_W-1:0] rd_flat,
`ifdef WBQ_BYPASS_EN
  input  logic [DEPTH*DATA_W-1:0] data_flat,
  input  logic [PTR_W-1:0]        wr_ptr,
`endif
  input  logic [DEPTH-1:0]        valid,
  input  logic [ADDR_W-1:0]       src,
  output logic                    hit,
  output logic [DATA_W-1:0]       data
);

  logic [DEPTH-1:0] match_s;

  // Per-entry match: stored, same index, and never for the hardwired x0.
  always_comb begin
    match_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = valid[i] &&
                   (rd_flat[i*ADDR_W +: ADDR_W] == src) &&
                   (src != {ADDR_W{1'b0}});
    end
  end

  assign hit = |match_s;

`ifdef WBQ_BYPASS_EN
  logic [DATA_W-1:0] data_s;

  // Walk from oldest slot to youngest so the entry nearest wr_ptr wins.
  always_comb begin
    logic [PTR_W-1:0] idx_v;
    idx_v  = {PTR_W{1'b0}};
    data_s = {DATA_W{1'b0}};
    for (int k = DEPTH; k >= 1; k--) begin
      idx_v  = PTR_W'(wr_ptr - PTR_W'(k));
      data_s = match_s[idx_v] ? data_flat[idx_v*DATA_W +: DATA_W] : data_s;
    end
  end

  assign data = data_s;
`else
  assign data = {DATA_W{1'b0}};
`endif

endmodule

// File: rtl/wb_write_queue.sv
// In-order write-back queue in front of the register-file write port.
// Producers enqueue through wb_valid/wb_ready; the head drains whenever
// rf_grant is high. Two lookup ports report pending writes to decode.
// Optional feature macro: WBQ_BYPASS_EN (lookup data forwarding).
module wb_write_queue
  import wbq_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = WBQ_ADDR_W,
  parameter int unsigned DATA_W = WBQ_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              rf_grant,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_dest,
  output logic [DATA_W-1:0] rf_data,
  input  logic [ADDR_W-1:0] lk_src_one,
  input  logic [ADDR_W-1:0] lk_src_two,
  output logic              lk_hit_one,
  output logic              lk_hit_two,
  output logic [DATA_W-1:0] lk_data_one,
  output logic [DATA_W-1:0] lk_data_two,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]       rd_mem_r   [DEPTH];
  logic [DATA_W-1:0]       data_mem_r [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic                    empty_s;
  logic                    full_s;
  logic                    ready_s;
  logic                    enq_s;
  logic                    deq_s;
  logic [ADDR_W-1:0]       rf_dest_s;
  logic [DATA_W-1:0]       rf_data_s;
  logic [DEPTH-1:0]        valid_s;
  logic [DEPTH*ADDR_W-1:0] rd_flat_s;
`ifdef WBQ_BYPASS_EN
  logic [DEPTH*DATA_W-1:0] data_flat_s;
`endif

  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign full_s  = (count_r == CNT_W'(DEPTH));
  // No ready-through-dequeue: a full queue refuses even if the head drains now.
  assign ready_s = reset && !full_s;
  assign deq_s   = !empty_s && rf_grant;
  // x0 results complete the handshake but are never stored.
  assign enq_s   = wb_valid && ready_s && (wb_rd != {ADDR_W{1'b0}});

  // Pointer and occupancy bookkeeping; reset discards every pending entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (enq_s) begin
        wr_ptr_r <= PTR_W'(wbq_ptr_inc(WBQ_PTR_MAX_W'(wr_ptr_r), DEPTH));
      end
      if (deq_s) begin
        rd_ptr_r <= PTR_W'(wbq_ptr_inc(WBQ_PTR_MAX_W'(rd_ptr_r), DEPTH));
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage written at the write pointer on each accepted non-x0 result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_r[i]   <= {ADDR_W{1'b0}};
        data_mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (enq_s) begin
      rd_mem_r[wr_ptr_r]   <= wb_rd;
      data_mem_r[wr_ptr_r] <= wb_data;
    end
  end

  // Head presentation: the oldest entry, or zeros when nothing is pending.
  always_comb begin
    rf_dest_s = {ADDR_W{1'b0}};
    rf_data_s = {DATA_W{1'b0}};
    if (!empty_s) begin
      rf_dest_s = rd_mem_r[rd_ptr_r];
      rf_data_s = data_mem_r[rd_ptr_r];
    end else begin
      rf_dest_s = {ADDR_W{1'b0}};
      rf_data_s = {DATA_W{1'b0}};
    end
  end

  // Slot i is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    valid_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      valid_s[i] = (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr_r)) < count_r);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign rd_flat_s[g*ADDR_W +: ADDR_W] = rd_mem_r[g];
`ifdef WBQ_BYPASS_EN
    assign data_flat_s[g*DATA_W +: DATA_W] = data_mem_r[g];
`endif
  end

  wbq_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_match_one (
    .rd_flat   (rd_flat_s),
`ifdef WBQ_BYPASS_EN
    .data_flat (data_flat_s),
    .wr_ptr    (wr_ptr_r),
`endif
    .valid     (valid_s),
    .src       (lk_src_one),
    .hit       (lk_hit_one),
    .data      (lk_data_one)
  );

  wbq_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_match_two (
    .rd_flat   (rd_flat_s),
`ifdef WBQ_BYPASS_EN
    .data_flat (data_flat_s),
    .wr_ptr    (wr_ptr_r),
`endif
    .valid     (valid_s),
    .src       (lk_src_two),
    .hit       (lk_hit_two),
    .data      (lk_data_two)
  );

  assign wb_ready        = ready_s;
  assign rf_write_enable = deq_s;
  assign rf_dest         = rf_dest_s;
  assign rf_data         = rf_data_s;
  assign empty           = empty_s;
  assign full            = full_s;

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 unit later, well before the next edge.
module tb_wb_write_queue;
  import wbq_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
`ifdef WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wb_valid = 1'b0;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_rd = 5'd0;
  logic [DATA_W-1:0] wb_data = 32'd0;
  logic              rf_grant = 1'b0;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] rf_dest;
  logic [DATA_W-1:0] rf_data;
  logic [ADDR_W-1:0] lk_src_one = 5'd0;
  logic [ADDR_W-1:0] lk_src_two = 5'd0;
  logic              lk_hit_one;
  logic              lk_hit_two;
  logic [DATA_W-1:0] lk_data_one;
  logic [DATA_W-1:0] lk_data_two;
  logic              empty;
  logic              full;

  int checks   = 0;
  int failures = 0;
  wbq_entry_t exp_q[$];

  wb_write_queue #(.DEPTH(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .rf_grant        (rf_grant),
    .rf_write_enable (rf_write_enable),
    .rf_dest         (rf_dest),
    .rf_data         (rf_data),
    .lk_src_one      (lk_src_one),
    .lk_src_two      (lk_src_two),
    .lk_hit_one      (lk_hit_one),
    .lk_hit_two      (lk_hit_two),
    .lk_data_one     (lk_data_one),
    .lk_data_two     (lk_data_two),
    .empty           (empty),
    .full            (full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [DATA_W-1:0] byp(input logic [DATA_W-1:0] d);
    return BYP ? d : 32'd0;
  endfunction

  task automatic test_reset();
    reset = 1'b0; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234_5678;
    rf_grant = 1'b1; lk_src_one = 5'd5; lk_src_two = 5'd5;
    step(); step(); settle();
    checks++;
    if ({wb_ready, rf_write_enable, empty, full} !== 4'b0010) begin
      failures++; $display("FAIL reset_status: got %b expected 0010", {wb_ready, rf_write_enable, empty, full});
    end
    checks++;
    if ({rf_dest, rf_data} !== 37'd0) begin
      failures++; $display("FAIL reset_head: got %h expected 0", {rf_dest, rf_data});
    end
    checks++;
    if ({lk_hit_one, lk_hit_two, lk_data_one, lk_data_two} !== 66'd0) begin
      failures++; $display("FAIL reset_lookup: got %h expected 0", {lk_hit_one, lk_hit_two, lk_data_one, lk_data_two});
    end
    wb_valid = 1'b0; reset = 1'b1; settle();
    checks++;
    if ({wb_ready, empty, rf_write_enable} !== 3'b110) begin
      failures++; $display("FAIL reset_release: got %b expected 110", {wb_ready, empty, rf_write_enable});
    end
    step();
  endtask

  task automatic test_reset_mid();
    rf_grant = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wb_valid = 1'b1; wb_rd = 5'(i); wb_data = 32'hC000_0000 + 32'(i);
      step();
    end
    wb_valid = 1'b0; lk_src_one = 5'd2; settle();
    checks++;
    if ({empty, rf_dest, lk_hit_one} !== {1'b0, 5'd1, 1'b1}) begin
      failures++; $display("FAIL mid_prefill: got %b expected 0_00001_1", {empty, rf_dest, lk_hit_one});
    end
    rf_grant = 1'b1; reset = 1'b0; settle();
    checks++;
    if ({empty, rf_write_enable, wb_ready, lk_hit_one, rf_dest} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      failures++; $display("FAIL mid_reset: got %b expected 1000_00000", {empty, rf_write_enable, wb_ready, lk_hit_one, rf_dest});
    end
    step(); reset = 1'b1; settle();
    checks++;
    if ({wb_ready, empty, rf_write_enable} !== 3'b110) begin
      failures++; $display("FAIL mid_release: got %b expected 110", {wb_ready, empty, rf_write_enable});
    end
    step(); settle();
    checks++;
    if ({empty, rf_write_enable, lk_hit_one} !== 3'b100) begin
      failures++; $display("FAIL mid_no_stale: got %b expected 100", {empty, rf_write_enable, lk_hit_one});
    end
  endtask

  task automatic test_basic();
    rf_grant = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF; settle();
    checks++;
    if ({wb_ready, rf_write_enable} !== 2'b10) begin
      failures++; $display("FAIL basic_accept: got %b expected 10", {wb_ready, rf_write_enable});
    end
    step(); wb_valid = 1'b0; settle();
    checks++;
    if ({rf_write_enable, rf_dest, rf_data, empty} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0}) begin
      failures++; $display("FAIL basic_head: got %h expected %h", {rf_write_enable, rf_dest, rf_data, empty}, {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0});
    end
    step(); settle();
    checks++;
    if ({empty, rf_write_enable} !== 2'b10) begin
      failures++; $display("FAIL basic_drained: got %b expected 10", {empty, rf_write_enable});
    end
  endtask

  task automatic test_full_wrap();
    logic [DATA_W-1:0] d [1:5];
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= 5; i++) d[i] = 32'hA000_0000 + 32'(r * 256) + 32'(i);
      rf_grant = 1'b0;
      for (int i = 1; i <= 4; i++) begin
        wb_valid = 1'b1; wb_rd = 5'(i); wb_data = d[i];
        step();
      end
      wb_rd = 5'd5; wb_data = d[5]; settle();
      checks++;
      if ({full, wb_ready, empty} !== 3'b100) begin
        failures++; $display("FAIL wrap%0d_full: got %b expected 100", r, {full, wb_ready, empty});
      end
      step(); settle();
      checks++;
      if ({full, rf_write_enable, rf_dest, rf_data} !== {1'b1, 1'b0, 5'd1, d[1]}) begin
        failures++; $display("FAIL wrap%0d_stall: got %h expected %h", r, {full, rf_write_enable, rf_dest, rf_data}, {1'b1, 1'b0, 5'd1, d[1]});
      end
      rf_grant = 1'b1; settle();
      checks++;
      if ({wb_ready, rf_write_enable, rf_dest, rf_data} !== {1'b0, 1'b1, 5'd1, d[1]}) begin
        failures++; $display("FAIL wrap%0d_drain1: got %h expected %h", r, {wb_ready, rf_write_enable, rf_dest, rf_data}, {1'b0, 1'b1, 5'd1, d[1]});
      end
      step(); settle();
      checks++;
      if ({wb_ready, rf_write_enable, rf_dest, rf_data} !== {1'b1, 1'b1, 5'd2, d[2]}) begin
        failures++; $display("FAIL wrap%0d_drain2: got %h expected %h", r, {wb_ready, rf_write_enable, rf_dest, rf_data}, {1'b1, 1'b1, 5'd2, d[2]});
      end
      step(); wb_valid = 1'b0;
      for (int j = 3; j <= 5; j++) begin
        settle();
        checks++;
        if ({rf_write_enable, rf_dest, rf_data} !== {1'b1, 5'(j), d[j]}) begin
          failures++; $display("FAIL wrap%0d_drain%0d: got %h expected %h", r, j, {rf_write_enable, rf_dest, rf_data}, {1'b1, 5'(j), d[j]});
        end
        step();
      end
      settle();
      checks++;
      if ({empty, rf_write_enable} !== 2'b10) begin
        failures++; $display("FAIL wrap%0d_empty: got %b expected 10", r, {empty, rf_write_enable});
      end
    end
  endtask

  task automatic test_x0();
    rf_grant = 1'b0; lk_src_one = 5'd0; lk_src_two = 5'd0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_0055; settle();
    checks++;
    if (wb_ready !== 1'b1) begin
      failures++; $display("FAIL x0_ready: got %b expected 1", wb_ready);
    end
    step(); wb_valid = 1'b0; settle();
    checks++;
    if ({empty, lk_hit_one} !== 2'b10) begin
      failures++; $display("FAIL x0_discard: got %b expected 10", {empty, lk_hit_one});
    end
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_0077;
    step(); wb_valid = 1'b0; lk_src_two = 5'd7; settle();
    checks++;
    if ({lk_hit_one, lk_hit_two, lk_data_two} !== {1'b0, 1'b1, byp(32'h0000_0077)}) begin
      failures++; $display("FAIL x0_lookup: got %h expected %h", {lk_hit_one, lk_hit_two, lk_data_two}, {1'b0, 1'b1, byp(32'h0000_0077)});
    end
    rf_grant = 1'b1; settle();
    checks++;
    if ({rf_write_enable, rf_dest, rf_data} !== {1'b1, 5'd7, 32'h0000_0077}) begin
      failures++; $display("FAIL x0_head: got %h expected %h", {rf_write_enable, rf_dest, rf_data}, {1'b1, 5'd7, 32'h0000_0077});
    end
    step(); settle();
    checks++;
    if ({empty, rf_write_enable, lk_hit_two} !== 3'b100) begin
      failures++; $display("FAIL x0_only_one: got %b expected 100", {empty, rf_write_enable, lk_hit_two});
    end
  endtask

  task automatic test_youngest();
    rf_grant = 1'b0; lk_src_one = 5'd3; lk_src_two = 5'd4;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0011; settle();
    checks++;
    if (lk_hit_one !== 1'b0) begin
      failures++; $display("FAIL young_same_cycle: got %b expected 0", lk_hit_one);
    end
    step(); wb_data = 32'h0000_0022; settle();
    checks++;
    if ({lk_hit_one, lk_data_one} !== {1'b1, byp(32'h0000_0011)}) begin
      failures++; $display("FAIL young_first: got %h expected %h", {lk_hit_one, lk_data_one}, {1'b1, byp(32'h0000_0011)});
    end
    step(); wb_valid = 1'b0; settle();
    checks++;
    if ({lk_hit_one, lk_data_one, lk_hit_two, lk_data_two} !== {1'b1, byp(32'h0000_0022), 1'b0, 32'd0}) begin
      failures++; $display("FAIL young_pick: got %h expected %h", {lk_hit_one, lk_data_one, lk_hit_two, lk_data_two}, {1'b1, byp(32'h0000_0022), 1'b0, 32'd0});
    end
    lk_src_two = 5'd3; rf_grant = 1'b1; settle();
    checks++;
    if ({rf_write_enable, rf_data, lk_hit_two, lk_data_two} !== {1'b1, 32'h0000_0011, 1'b1, byp(32'h0000_0022)}) begin
      failures++; $display("FAIL young_head_drain: got %h expected %h", {rf_write_enable, rf_data, lk_hit_two, lk_data_two}, {1'b1, 32'h0000_0011, 1'b1, byp(32'h0000_0022)});
    end
    step(); settle();
    checks++;
    if ({rf_data, lk_hit_one, lk_data_one} !== {32'h0000_0022, 1'b1, byp(32'h0000_0022)}) begin
      failures++; $display("FAIL young_second: got %h expected %h", {rf_data, lk_hit_one, lk_data_one}, {32'h0000_0022, 1'b1, byp(32'h0000_0022)});
    end
    step(); settle();
    checks++;
    if ({empty, lk_hit_one, lk_hit_two, lk_data_one} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      failures++; $display("FAIL young_gone: got %h expected %h", {empty, lk_hit_one, lk_hit_two, lk_data_one}, {1'b1, 1'b0, 1'b0, 32'd0});
    end
  endtask

  task automatic test_back_to_back();
    wbq_entry_t e;
    rf_grant = 1'b0; exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      wb_valid = 1'b1; wb_rd = 5'(10 + i); wb_data = 32'h0000_0100 + 32'(i);
      e.rd = wb_rd; e.data = wb_data; exp_q.push_back(e);
      step();
    end
    rf_grant = 1'b1;
    for (int c = 0; c < 10; c++) begin
      wb_valid = 1'b1; wb_rd = 5'(12 + c); wb_data = 32'h0000_0102 + 32'(c); settle();
      checks++;
      if ({rf_write_enable, empty, full, wb_ready, rf_dest, rf_data} !== {4'b1001, exp_q[0]}) begin
        failures++; $display("FAIL b2b_cycle%0d: got %h expected %h", c, {rf_write_enable, empty, full, wb_ready, rf_dest, rf_data}, {4'b1001, exp_q[0]});
      end
      e.rd = wb_rd; e.data = wb_data;
      step();
      void'(exp_q.pop_front()); exp_q.push_back(e);
    end
    wb_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if ({rf_write_enable, rf_dest, rf_data} !== {1'b1, exp_q[0]}) begin
        failures++; $display("FAIL b2b_tail%0d: got %h expected %h", i, {rf_write_enable, rf_dest, rf_data}, {1'b1, exp_q[0]});
      end
      step();
      void'(exp_q.pop_front());
    end
    settle();
    checks++;
    if ({empty, rf_write_enable} !== 2'b10) begin
      failures++; $display("FAIL b2b_empty: got %b expected 10", {empty, rf_write_enable});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid();
    test_basic();
    test_full_wrap();
    test_x0();
    test_youngest();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
